// File: rtl/calc_op_scheduler_pkg.sv
// Shared types and constants for the calculator operation scheduler.
package calc_op_scheduler_pkg;

  localparam int unsigned N_UNITS_DEF     = 4;
  localparam int unsigned RES_W_DEF       = 32;
  localparam int unsigned TIMEOUT_CYC_DEF = 64;
  localparam int unsigned OP_W            = 2;

  // Operation unit indices carried on op_code
  localparam logic [OP_W-1:0] OP_MUL  = 2'd0;
  localparam logic [OP_W-1:0] OP_DIV  = 2'd1;
  localparam logic [OP_W-1:0] OP_POW  = 2'd2;
  localparam logic [OP_W-1:0] OP_SQRT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Status flags that travel with a latched result
  typedef struct packed {
    logic err;
    logic sign;
    logic ovf;
  } res_flags_t;

endpackage

// File: rtl/calc_op_scheduler_if.sv
// Request, unit-control and result signals between the scheduler and its neighbours.
interface calc_op_scheduler_if #(
  parameter int unsigned N_UNITS = calc_op_scheduler_pkg::N_UNITS_DEF,
  parameter int unsigned RES_W   = calc_op_scheduler_pkg::RES_W_DEF
) ();

  logic                             op_valid;
  logic                             op_ready;
  logic [calc_op_scheduler_pkg::OP_W-1:0] op_code;
  logic                             op_abort;
  logic [N_UNITS-1:0]               unit_rst;
  logic [N_UNITS-1:0]               unit_start;
  logic [N_UNITS-1:0]               unit_done;
  logic [N_UNITS*RES_W-1:0]         unit_result;
  logic [N_UNITS-1:0]               unit_sign;
  logic [N_UNITS-1:0]               unit_ovf;
  logic                             res_valid;
  logic                             res_ack;
  logic [RES_W-1:0]                 result;
  logic                             res_sign;
  logic                             res_ovf;
  logic                             res_err;

  // Requester, operation units and result consumer as seen from outside
  modport master (
    output op_valid, op_code, op_abort, unit_done, unit_result, unit_sign, unit_ovf, res_ack,
    input  op_ready, unit_rst, unit_start, res_valid, result, res_sign, res_ovf, res_err
  );

  // The scheduler itself
  modport slave (
    input  op_valid, op_code, op_abort, unit_done, unit_result, unit_sign, unit_ovf, res_ack,
    output op_ready, unit_rst, unit_start, res_valid, result, res_sign, res_ovf, res_err
  );

endinterface

// File: rtl/calc_op_scheduler_timeout_cnt.sv
// Clear/enable up-counter that flags when it sits on LIMIT-1.
module calc_op_scheduler_timeout_cnt #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over count; stop at the terminal value
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/calc_op_scheduler.sv
// Runs one multi-cycle operation unit at a time and holds its result for the consumer.
module calc_op_scheduler
  import calc_op_scheduler_pkg::*;
#(
  parameter int unsigned N_UNITS     = N_UNITS_DEF,
  parameter int unsigned RES_W       = RES_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic                clk,
  input logic                rst,
  calc_op_scheduler_if.slave bus
);

  state_e           state_q, state_d;
  logic [OP_W-1:0]  sel_q, sel_d;
  logic [RES_W-1:0] cap_val_q, cap_val_d;
  res_flags_t       cap_flags_q, cap_flags_d;
  logic             abort_hit;
  logic             timeout_tc;

  logic             sel_done, sel_sign, sel_ovf;
  logic [RES_W-1:0] sel_result;

  logic               op_ready_q, op_ready_d;
  logic [N_UNITS-1:0] unit_rst_q, unit_rst_d;
  logic [N_UNITS-1:0] unit_start_q, unit_start_d;
  logic               res_valid_q, res_valid_d;
  logic [RES_W-1:0]   result_q, result_d;
  res_flags_t         res_flags_q, res_flags_d;

  calc_op_scheduler_timeout_cnt #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .clr_i(state_q == ST_CLEAR),
    .en_i (state_q == ST_RUN),
    .tc_o (timeout_tc)
  );

  // Pick the selected unit's done/result/flags; other units are ignored
  always_comb begin
    sel_done   = 1'b0;
    sel_sign   = 1'b0;
    sel_ovf    = 1'b0;
    sel_result = '0;
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      if (sel_q == OP_W'(i)) begin
        sel_done   = bus.unit_done[i];
        sel_sign   = bus.unit_sign[i];
        sel_ovf    = bus.unit_ovf[i];
        sel_result = bus.unit_result[i*RES_W +: RES_W];
      end
    end
  end

  // State, selection and captured result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      cap_val_q   <= '0;
      cap_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cap_val_q   <= cap_val_d;
      cap_flags_q <= cap_flags_d;
    end
  end

  // Next state; in RUN abort beats done, done beats timeout
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cap_val_d   = cap_val_q;
    cap_flags_d = cap_flags_q;
    abort_hit   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.op_valid) begin
          sel_d = bus.op_code;
          if (32'(bus.op_code) >= N_UNITS) begin
            state_d     = ST_HOLD;
            cap_val_d   = '0;
            cap_flags_d = '{err: 1'b1, sign: 1'b0, ovf: 1'b0};
          end else begin
            state_d = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        if (bus.op_abort) begin
          state_d   = ST_IDLE;
          abort_hit = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.op_abort) begin
          state_d   = ST_IDLE;
          abort_hit = 1'b1;
        end else if (sel_done) begin
          state_d     = ST_HOLD;
          cap_val_d   = sel_result;
          cap_flags_d = '{err: 1'b0, sign: sel_sign, ovf: sel_ovf};
        end else if (timeout_tc) begin
          state_d     = ST_HOLD;
          cap_val_d   = '0;
          cap_flags_d = '{err: 1'b1, sign: 1'b0, ovf: 1'b0};
        end
      end
      ST_HOLD: begin
        if (bus.res_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values: unit controls follow the next state, result side trails HOLD by a cycle
  always_comb begin
    op_ready_d   = 1'b0;
    unit_rst_d   = '0;
    unit_start_d = '0;
    res_valid_d  = 1'b0;
    result_d     = '0;
    res_flags_d  = '0;
    if (state_d == ST_IDLE) begin
      op_ready_d = 1'b1;
    end
    if ((state_d == ST_CLEAR) || abort_hit) begin
      unit_rst_d = N_UNITS'(1) << sel_d;
    end
    if (state_d == ST_RUN) begin
      unit_start_d = N_UNITS'(1) << sel_d;
    end
    if (state_q == ST_HOLD) begin
      res_valid_d = 1'b1;
      result_d    = cap_val_q;
      res_flags_d = cap_flags_q;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_ready_q   <= 1'b1;
      unit_rst_q   <= '0;
      unit_start_q <= '0;
      res_valid_q  <= 1'b0;
      result_q     <= '0;
      res_flags_q  <= '0;
    end else begin
      op_ready_q   <= op_ready_d;
      unit_rst_q   <= unit_rst_d;
      unit_start_q <= unit_start_d;
      res_valid_q  <= res_valid_d;
      result_q     <= result_d;
      res_flags_q  <= res_flags_d;
    end
  end

  assign bus.op_ready   = op_ready_q;
  assign bus.unit_rst   = unit_rst_q;
  assign bus.unit_start = unit_start_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.result     = result_q;
  assign bus.res_sign   = res_flags_q.sign;
  assign bus.res_ovf    = res_flags_q.ovf;
  assign bus.res_err    = res_flags_q.err;

endmodule

// File: tb/tb_calc_op_scheduler.sv
// Directed bench for the operation scheduler with hand-computed expectations.
module tb_calc_op_scheduler;
  import calc_op_scheduler_pkg::*;

  localparam int unsigned N_UNITS     = 4;
  localparam int unsigned RES_W       = 32;
  localparam int unsigned TIMEOUT_CYC = 64;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_start;

  calc_op_scheduler_if #(.N_UNITS(N_UNITS), .RES_W(RES_W)) bus ();

  calc_op_scheduler #(
    .N_UNITS    (N_UNITS),
    .RES_W      (RES_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a request for one cycle; returns just after the accepting edge
  task automatic request(input logic [OP_W-1:0] code);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    tick();
    bus.op_valid = 1'b0;
  endtask

  task automatic ack_result();
    bus.res_ack = 1'b1;
    tick();
    bus.res_ack = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst             = 1'b0;
    bus.op_valid    = 1'b0;
    bus.op_code     = '0;
    bus.op_abort    = 1'b0;
    bus.unit_done   = '0;
    bus.unit_result = '0;
    bus.unit_sign   = '0;
    bus.unit_ovf    = '0;
    bus.res_ack     = 1'b0;
    tick();
    tick();
    check("rst_op_ready", bus.op_ready, 1);
    check("rst_unit_rst", bus.unit_rst, 0);
    check("rst_unit_start", bus.unit_start, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_result", bus.result, 0);
    rst = 1'b1;
    tick();

    // Power unit, done after three RUN cycles
    bus.unit_result[64 +: 32] = 32'h0000_0051;
    request(OP_POW);
    check("pow_clear_rst", bus.unit_rst, 4'b0100);
    check("pow_clear_start", bus.unit_start, 4'b0000);
    check("pow_clear_ready", bus.op_ready, 0);
    tick();
    check("pow_run1_rst", bus.unit_rst, 4'b0000);
    check("pow_run1_start", bus.unit_start, 4'b0100);
    tick();
    check("pow_run2_start", bus.unit_start, 4'b0100);
    tick();
    check("pow_run3_start", bus.unit_start, 4'b0100);
    bus.unit_done = 4'b0100;
    tick();
    bus.unit_done = 4'b0000;
    check("pow_hold_start", bus.unit_start, 4'b0000);
    check("pow_hold_valid0", bus.res_valid, 0);
    tick();
    check("pow_valid", bus.res_valid, 1);
    check("pow_result", bus.result, 32'h51);
    check("pow_err", bus.res_err, 0);
    tick();
    tick();
    check("pow_valid_held", bus.res_valid, 1);
    check("pow_result_held", bus.result, 32'h51);
    check("pow_hold_ready", bus.op_ready, 0);
    bus.res_ack = 1'b1;
    tick();
    bus.res_ack = 1'b0;
    check("pow_ack_valid_lag", bus.res_valid, 1);
    check("pow_ack_ready", bus.op_ready, 1);
    tick();
    check("pow_after_ack_valid", bus.res_valid, 0);
    check("pow_after_ack_result", bus.result, 0);

    // Minimum latency: divider done on the first RUN cycle with overflow
    bus.unit_result[32 +: 32] = 32'h0000_1234;
    bus.unit_sign = 4'b0010;
    bus.unit_ovf  = 4'b0010;
    bus.unit_done = 4'b0010;
    request(OP_DIV);
    tick();
    check("min_t1_valid", bus.res_valid, 0);
    tick();
    bus.unit_done = 4'b0000;
    check("min_t2_valid", bus.res_valid, 0);
    tick();
    check("min_t3_valid", bus.res_valid, 1);
    check("min_ovf", bus.res_ovf, 1);
    check("min_sign", bus.res_sign, 1);
    check("min_result", bus.result, 32'h1234);
    ack_result();
    bus.unit_sign = 4'b0000;
    bus.unit_ovf  = 4'b0000;

    // Timeout: multiplier never finishes
    bus.unit_sign = 4'b0001;
    bus.unit_ovf  = 4'b0001;
    request(OP_MUL);
    tick();
    n_start = 0;
    while ((bus.unit_start == 4'b0001) && (n_start < 200)) begin
      n_start++;
      tick();
    end
    check("to_run_cycles", n_start, 64);
    check("to_hold_valid0", bus.res_valid, 0);
    tick();
    check("to_valid", bus.res_valid, 1);
    check("to_err", bus.res_err, 1);
    check("to_result", bus.result, 0);
    check("to_sign", bus.res_sign, 0);
    check("to_ovf", bus.res_ovf, 0);
    ack_result();
    bus.unit_sign = 4'b0000;
    bus.unit_ovf  = 4'b0000;

    // Abort and done on the same RUN edge
    bus.unit_result[96 +: 32] = 32'hDEAD_BEEF;
    request(OP_SQRT);
    tick();
    check("ab_run_start", bus.unit_start, 4'b1000);
    bus.op_abort  = 1'b1;
    bus.unit_done = 4'b1000;
    tick();
    bus.op_abort  = 1'b0;
    bus.unit_done = 4'b0000;
    check("ab_rst_pulse", bus.unit_rst, 4'b1000);
    check("ab_start_off", bus.unit_start, 4'b0000);
    check("ab_ready", bus.op_ready, 1);
    check("ab_valid0", bus.res_valid, 0);
    tick();
    check("ab_rst_end", bus.unit_rst, 4'b0000);
    check("ab_valid1", bus.res_valid, 0);

    // Request during HOLD is ignored, then accepted on the first IDLE cycle
    bus.unit_done = 4'b0010;
    request(OP_DIV);
    tick();
    tick();
    bus.unit_done = 4'b0000;
    bus.op_valid  = 1'b1;
    bus.op_code   = OP_SQRT;
    tick();
    check("hq_valid", bus.res_valid, 1);
    check("hq_rst", bus.unit_rst, 4'b0000);
    tick();
    check("hq_rst2", bus.unit_rst, 4'b0000);
    check("hq_ready", bus.op_ready, 0);
    bus.res_ack = 1'b1;
    tick();
    bus.res_ack = 1'b0;
    check("hq_idle_ready", bus.op_ready, 1);
    tick();
    bus.op_valid = 1'b0;
    check("hq_accept_rst", bus.unit_rst, 4'b1000);
    check("hq_accept_ready", bus.op_ready, 0);
    bus.op_abort = 1'b1;
    tick();
    bus.op_abort = 1'b0;
    check("hq_abort_rst", bus.unit_rst, 4'b1000);
    check("hq_abort_ready", bus.op_ready, 1);
    tick();

    // Reset in the middle of RUN
    request(OP_MUL);
    tick();
    check("mr_run_start", bus.unit_start, 4'b0001);
    rst = 1'b0;
    tick();
    check("mr_ready", bus.op_ready, 1);
    check("mr_start", bus.unit_start, 4'b0000);
    check("mr_rst_out", bus.unit_rst, 4'b0000);
    check("mr_valid", bus.res_valid, 0);
    tick();
    rst = 1'b1;
    tick();
    check("mr_ready_after", bus.op_ready, 1);
    check("mr_start_after", bus.unit_start, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
